// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction encoder for the program loader.
// Packs decoded micro-op fields (format, ALU op, rs1/rs2/rd, immediate) into
// 32-bit instruction words and emits them at sequential word addresses.
// Optional feature macro: INST_ENC_RANGE_CHECK_EN enables immediate
// range/alignment checking (err_code 2). Without it, immediates are
// truncated to their encoded fields.
module inst_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [7:0]        op,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_JAL   = 3'd2;
  localparam logic [2:0] FMT_JALR  = 3'd3;
  localparam logic [2:0] FMT_LUI   = 3'd4;
  localparam logic [2:0] FMT_AUIPC = 3'd5;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_FULL    = 2'd3;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op_known;
  logic        is_shift;
  logic        illegal;
  logic        range_err;
  logic [31:0] enc;
  logic        accept;

  // ALU op decode: funct3/funct7 selection and legality of the op code
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    op_known = 1'b1;
    is_shift = 1'b0;
    case (op)
      8'h01: funct3 = 3'b000;
      8'h02: begin funct3 = 3'b000; funct7 = 7'b0100000; end
      8'h03: begin funct3 = 3'b001; is_shift = 1'b1; end
      8'h04: funct3 = 3'b010;
      8'h05: funct3 = 3'b011;
      8'h06: funct3 = 3'b100;
      8'h07: begin funct3 = 3'b101; is_shift = 1'b1; end
      8'h08: begin funct3 = 3'b101; funct7 = 7'b0100000; is_shift = 1'b1; end
      8'h09: funct3 = 3'b110;
      8'h0a: funct3 = 3'b111;
      default: op_known = 1'b0;
    endcase
  end

  // Format/op legality and (optionally) immediate range checking
  always_comb begin
    illegal   = 1'b0;
    range_err = 1'b0;
    case (fmt)
      FMT_R:     illegal = !op_known;
      FMT_I:     illegal = !op_known || (op == 8'h02);
      FMT_JAL, FMT_JALR, FMT_LUI, FMT_AUIPC: illegal = 1'b0;
      default:   illegal = 1'b1;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    case (fmt)
      FMT_I: begin
        if (is_shift) range_err = |imm[31:5];
        else          range_err = !((imm[31:11] == '0) || (imm[31:11] == '1));
      end
      FMT_JALR:  range_err = !((imm[31:11] == '0) || (imm[31:11] == '1));
      FMT_JAL:   range_err = imm[0] || !((imm[31:20] == '0) || (imm[31:20] == '1));
      FMT_LUI, FMT_AUIPC: range_err = |imm[11:0];
      default:   range_err = 1'b0;
    endcase
`else
    range_err = 1'b0;
`endif
  end

  // Instruction word packing for each supported format
  always_comb begin
    enc = 32'h0;
    case (fmt)
      FMT_R:     enc = {funct7, ra2, ra1, funct3, wa, 7'b0110011};
      FMT_I: begin
        if (is_shift) enc = {funct7, imm[4:0], ra1, funct3, wa, 7'b0010011};
        else          enc = {imm[11:0], ra1, funct3, wa, 7'b0010011};
      end
      FMT_JAL:   enc = {imm[20], imm[10:1], imm[11], imm[19:12], wa, 7'b1101111};
      FMT_JALR:  enc = {imm[11:0], ra1, 3'b000, wa, 7'b1100111};
      FMT_LUI:   enc = {imm[31:12], wa, 7'b0110111};
      FMT_AUIPC: enc = {imm[31:12], wa, 7'b0010111};
      default:   enc = 32'h0;
    endcase
  end

  // Handshake, FSM next state, address/count advance and error capture
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    count_d     = count_q;

    in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && !start;
    accept   = in_valid && in_ready;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (start) begin
      state_d     = RUN;
      addr_d      = ADDR_W'(BASE_ADDR);
      count_d     = '0;
      err_d       = 1'b0;
      err_code_d  = 2'd0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (illegal) begin
              err_d      = 1'b1;
              err_code_d = ERR_ILLEGAL;
            end else if (range_err) begin
              err_d      = 1'b1;
              err_code_d = ERR_RANGE;
            end else begin
              out_valid_d = 1'b1;
              out_data_d  = enc;
              out_addr_d  = addr_q;
              count_d     = count_q + (ADDR_W+1)'(1);
              if (addr_q == '1) state_d = FULL;
              else              addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
        FULL: begin
          if (in_valid) begin
            err_d      = 1'b1;
            err_code_d = ERR_FULL;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= 32'h0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign full      = (state_q == FULL);
  assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed self-checking bench for inst_encoder, using a
// 2-bit address space so the FULL behaviour is reachable quickly.
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [7:0]  op;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_addr;
  logic [31:0] out_data;
  logic        err;
  logic [1:0]  err_code;
  logic        full;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .ra1(ra1), .ra2(ra2), .wa(wa), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .err(err), .err_code(err_code), .full(full), .count(count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] f, input logic [7:0] o,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] w, input logic [31:0] i);
    in_valid = v;
    fmt      = f;
    op       = o;
    ra1      = r1;
    ra2      = r2;
    wa       = w;
    imm      = i;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    tick(); tick();
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready",  32'(in_ready), 0);
    checkOutput("rst_out_addr",  32'(out_addr), 0);
    checkOutput("rst_out_data",  out_data, 0);
    checkOutput("rst_err",       32'(err), 0);
    checkOutput("rst_err_code",  32'(err_code), 0);
    checkOutput("rst_full",      32'(full), 0);
    checkOutput("rst_count",     32'(count), 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_in_ready", 32'(in_ready), 0);

    // addi x1,x0,5
    start = 1'b1; tick(); start = 1'b0; #1;
    checkOutput("run_in_ready", 32'(in_ready), 1);
    applyStimulus(1'b1, 3'd1, 8'h01, 5'd0, 5'd0, 5'd1, 32'd5);
    tick(); in_valid = 1'b0;
    checkOutput("addi_valid", 32'(out_valid), 1);
    checkOutput("addi_data",  out_data, 32'h00500093);
    checkOutput("addi_addr",  32'(out_addr), 0);
    checkOutput("addi_count", 32'(count), 1);
    tick();
    checkOutput("addi_drained", 32'(out_valid), 0);

    // add then sub back-to-back
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'h01, 5'd1, 5'd2, 5'd3, 32'h0);
    tick();
    checkOutput("add_data", out_data, 32'h002081B3);
    checkOutput("add_addr", 32'(out_addr), 0);
    applyStimulus(1'b1, 3'd0, 8'h02, 5'd1, 5'd2, 5'd3, 32'h0);
    tick(); in_valid = 1'b0;
    checkOutput("sub_data",  out_data, 32'h402081B3);
    checkOutput("sub_addr",  32'(out_addr), 1);
    checkOutput("sub_count", 32'(count), 2);
    tick();

    // jal, lui, srai, backpressure hold, then fill the address space
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(1'b1, 3'd2, 8'h00, 5'd0, 5'd0, 5'd1, 32'd8);
    tick();
    checkOutput("jal_data", out_data, 32'h008000EF);
    checkOutput("jal_addr", 32'(out_addr), 0);
    applyStimulus(1'b1, 3'd4, 8'h00, 5'd0, 5'd0, 5'd5, 32'h12345000);
    tick();
    checkOutput("lui_data", out_data, 32'h123452B7);
    checkOutput("lui_addr", 32'(out_addr), 1);
    applyStimulus(1'b1, 3'd1, 8'h08, 5'd4, 5'd0, 5'd4, 32'd3);
    tick();
    checkOutput("srai_data", out_data, 32'h40325213);
    checkOutput("srai_addr", 32'(out_addr), 2);
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 8'h01, 5'd0, 5'd0, 5'd2, 32'd7);
    #1;
    checkOutput("hold_in_ready", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("hold_valid", 32'(out_valid), 1);
      checkOutput("hold_data",  out_data, 32'h40325213);
      checkOutput("hold_addr",  32'(out_addr), 2);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("last_data",  out_data, 32'h00700113);
    checkOutput("last_addr",  32'(out_addr), 3);
    checkOutput("last_full",  32'(full), 1);
    checkOutput("last_count", 32'(count), 4);
    #1;
    checkOutput("full_in_ready", 32'(in_ready), 0);
    tick(); in_valid = 1'b0;
    checkOutput("full_err",      32'(err), 1);
    checkOutput("full_err_code", 32'(err_code), 3);
    checkOutput("full_count",    32'(count), 4);
    checkOutput("full_drained",  32'(out_valid), 0);
    checkOutput("full_still",    32'(full), 1);
    start = 1'b1; #1;
    checkOutput("start_in_ready", 32'(in_ready), 0);
    tick(); start = 1'b0;
    checkOutput("restart_full",     32'(full), 0);
    checkOutput("restart_err",      32'(err), 0);
    checkOutput("restart_err_code", 32'(err_code), 0);
    checkOutput("restart_count",    32'(count), 0);

    // immediate out of range, then illegal format
    applyStimulus(1'b1, 3'd1, 8'h01, 5'd0, 5'd0, 5'd1, 32'd4096);
    tick();
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("range_valid",    32'(out_valid), 0);
    checkOutput("range_err",      32'(err), 1);
    checkOutput("range_err_code", 32'(err_code), 2);
`else
    checkOutput("trunc_valid", 32'(out_valid), 1);
    checkOutput("trunc_data",  out_data, 32'h00000093);
    checkOutput("trunc_err",   32'(err), 0);
`endif
    applyStimulus(1'b1, 3'd1, 8'h01, 5'd0, 5'd0, 5'd1, 32'd5);
    tick();
    checkOutput("after_range_data", out_data, 32'h00500093);
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("after_range_addr", 32'(out_addr), 0);
`else
    checkOutput("after_range_addr", 32'(out_addr), 1);
`endif
    applyStimulus(1'b1, 3'd7, 8'h01, 5'd0, 5'd0, 5'd1, 32'd0);
    tick(); in_valid = 1'b0;
    checkOutput("fmt7_valid",    32'(out_valid), 0);
    checkOutput("fmt7_err",      32'(err), 1);
    checkOutput("fmt7_err_code", 32'(err_code), 1);
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("fmt7_count", 32'(count), 1);
`else
    checkOutput("fmt7_count", 32'(count), 2);
`endif

    // sub as I-ALU is illegal; then jalr, auipc, xor
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(1'b1, 3'd1, 8'h02, 5'd1, 5'd0, 5'd1, 32'd0);
    tick();
    checkOutput("subi_err",      32'(err), 1);
    checkOutput("subi_err_code", 32'(err_code), 1);
    checkOutput("subi_valid",    32'(out_valid), 0);
    checkOutput("subi_count",    32'(count), 0);
    applyStimulus(1'b1, 3'd3, 8'h00, 5'd2, 5'd0, 5'd1, 32'd12);
    tick();
    checkOutput("jalr_data", out_data, 32'h00C100E7);
    checkOutput("jalr_addr", 32'(out_addr), 0);
    applyStimulus(1'b1, 3'd5, 8'h00, 5'd0, 5'd0, 5'd3, 32'h00001000);
    tick();
    checkOutput("auipc_data", out_data, 32'h00001197);
    checkOutput("auipc_addr", 32'(out_addr), 1);
    applyStimulus(1'b1, 3'd0, 8'h06, 5'd6, 5'd7, 5'd5, 32'd0);
    tick(); in_valid = 1'b0;
    checkOutput("xor_data",  out_data, 32'h007342B3);
    checkOutput("xor_addr",  32'(out_addr), 2);
    checkOutput("xor_count", 32'(count), 3);
    tick();

    // start while a word is pending and an input is offered
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(1'b1, 3'd1, 8'h01, 5'd0, 5'd0, 5'd1, 32'd5);
    tick();
    out_ready = 1'b0; start = 1'b1;
    applyStimulus(1'b1, 3'd0, 8'h01, 5'd1, 5'd2, 5'd3, 32'h0);
    #1;
    checkOutput("drop_in_ready", 32'(in_ready), 0);
    tick(); start = 1'b0;
    checkOutput("drop_valid", 32'(out_valid), 0);
    checkOutput("drop_count", 32'(count), 0);
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    checkOutput("post_drop_data",  out_data, 32'h002081B3);
    checkOutput("post_drop_addr",  32'(out_addr), 0);
    checkOutput("post_drop_count", 32'(count), 1);

    // reset mid-stream
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checkOutput("midrst_valid",    32'(out_valid), 0);
    checkOutput("midrst_count",    32'(count), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
